// File: rtl/morse_pkg.sv
// Shared Morse symbol codes and receiver state encoding.
package morse_pkg;

  localparam logic [1:0] SYM_DIT = 2'b00;
  localparam logic [1:0] SYM_DAH = 2'b11;
  localparam logic [1:0] SYM_GAP = 2'b01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MARK   = 2'd1,
    SPACE  = 2'd2,
    WSPACE = 2'd3
  } morse_state_t;

endpackage

// File: rtl/key_debounce.sv
// Registers the raw keyed line and accepts a level change only after it
// has persisted for DEBOUNCE consecutive cycles.
module key_debounce #(
  parameter int unsigned DEBOUNCE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_db
);

  localparam int unsigned PW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic          key_q;
  logic [PW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q  <= 1'b0;
      key_db <= 1'b0;
      cnt    <= '0;
    end else begin
      key_q <= key_in;
      if (key_q == key_db) begin
        cnt <= '0;
      end else if (cnt == PW'(DEBOUNCE - 1)) begin
        key_db <= key_q;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_key_rx.sv
// Morse symbol slicer: debounces the keyed line, times marks and spaces,
// and emits one registered dit/dah/gap symbol per element.
module morse_key_rx
  import morse_pkg::*;
#(
  parameter int unsigned DIT_TICKS = 4,
  parameter int unsigned DEBOUNCE  = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic [0:1] ditDah,
  output logic       sym_valid
);

  localparam logic [CNT_W-1:0] DUR_MAX   = '1;
  localparam logic [CNT_W-1:0] DAH_MIN   = CNT_W'(2 * DIT_TICKS);
  // Edges are seen one cycle after key_db moves, so a space threshold is
  // met when dur shows threshold-1 with no rise pending in the same cycle.
  localparam logic [CNT_W-1:0] LGAP_HIT  = CNT_W'(2 * DIT_TICKS - 1);
  localparam logic [CNT_W-1:0] WGAP_HIT  = CNT_W'(5 * DIT_TICKS - 1);

  logic             key_db;
  logic             key_db_d;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] dur;
  morse_state_t     state;
  morse_state_t     state_nxt;
  logic             emit;
  logic [1:0]       sym_nxt;

  key_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .key_in(key_in),
    .key_db(key_db)
  );

  assign rise = key_db & ~key_db_d;
  assign fall = ~key_db & key_db_d;

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    sym_nxt   = SYM_GAP;
    case (state)
      IDLE: begin
        if (rise) state_nxt = MARK;
      end
      MARK: begin
        if (fall) begin
          emit      = 1'b1;
          sym_nxt   = (dur < DAH_MIN) ? SYM_DIT : SYM_DAH;
          state_nxt = SPACE;
        end
      end
      SPACE: begin
        if (rise) begin
          state_nxt = MARK;
        end else if (dur == LGAP_HIT) begin
          emit      = 1'b1;
          state_nxt = WSPACE;
        end
      end
      WSPACE: begin
        if (rise) begin
          state_nxt = MARK;
        end else if (dur == WGAP_HIT) begin
          emit      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_db_d  <= 1'b0;
      dur       <= '0;
      ditDah    <= SYM_GAP;
      sym_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      key_db_d  <= key_db;
      sym_valid <= emit;
      if (emit) ditDah <= sym_nxt;
      if (rise || fall) begin
        dur <= CNT_W'(1);
      end else if (dur != DUR_MAX) begin
        dur <= dur + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_morse_key_rx.sv
// Scoreboard bench for morse_key_rx: expected symbols and strobe cycles are
// queued as the keyed line is driven and matched against each sym_valid.
module tb_morse_key_rx;

  localparam int DIT = 4;
  localparam int DEB = 2;
  localparam logic [1:0] E_DIT = 2'b00;
  localparam logic [1:0] E_DAH = 2'b11;
  localparam logic [1:0] E_GAP = 2'b01;

  typedef struct {
    logic [1:0] sym;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_in = 1'b0;
  logic [0:1] ditDah;
  logic       sym_valid;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   strobes = 0;
  logic prev_valid = 1'b0;
  logic after_mark = 1'b0;
  exp_t sb[$];

  morse_key_rx #(
    .DIT_TICKS(DIT),
    .DEBOUNCE (DEB),
    .CNT_W    (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .ditDah   (ditDah),
    .sym_valid(sym_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks = checks + 1;
    if (obs != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (sym_valid) begin
      exp_t e;
      strobes = strobes + 1;
      check_eq("strobe_width", int'(prev_valid), 0);
      if (sb.size() == 0) begin
        check_eq("spurious_strobe", int'(sym_valid), 0);
      end else begin
        e = sb.pop_front();
        check_eq("symbol", int'(ditDah), int'(e.sym));
        check_eq("strobe_cycle", cyc, e.cyc);
      end
    end
    prev_valid = sym_valid;
  end

  task automatic hold(input logic lvl, input int n);
    key_in = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Clean mark of n cycles; the fall is driven by the next hold.
  task automatic mark(input int n);
    hold(1'b1, n);
    sb.push_back('{sym: (n < 2 * DIT) ? E_DIT : E_DAH, cyc: cyc + DEB + 2});
    after_mark = 1'b1;
  endtask

  task automatic space(input int n);
    if (after_mark) begin
      if (n >= 2 * DIT) sb.push_back('{sym: E_GAP, cyc: cyc + DEB + 1 + 2 * DIT});
      if (n >= 5 * DIT) sb.push_back('{sym: E_GAP, cyc: cyc + DEB + 1 + 5 * DIT});
    end
    after_mark = 1'b0;
    hold(1'b0, n);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_valid", int'(sym_valid), 0);
    check_eq("reset_sym", int'(ditDah), 1);
    rst = 1'b0;
    hold(1'b0, 10);

    // Letter A followed by a word gap
    base = strobes;
    mark(4); space(4); mark(12); space(30);
    check_eq("letterA_count", strobes - base, 4);

    // Dit/dah boundary
    mark(7); space(25);
    mark(8); space(25);

    // Glitch rejection: spike in a space, dropout inside a 12-cycle mark
    base = strobes;
    hold(1'b0, 10); hold(1'b1, 1); hold(1'b0, 15);
    hold(1'b1, 5); hold(1'b0, 1); hold(1'b1, 6);
    sb.push_back('{sym: E_DAH, cyc: cyc + DEB + 2});
    after_mark = 1'b1;
    space(25);
    check_eq("glitch_count", strobes - base, 3);

    // Gap thresholds on both sides
    base = strobes;
    mark(4); space(7);
    mark(4); space(8);
    mark(4); space(19);
    mark(4); space(20);
    hold(1'b0, 10);
    check_eq("gap_count", strobes - base, 8);

    // Saturating mark
    base = strobes;
    hold(1'b1, 300);
    check_eq("dur_saturated", int'(dut.dur), 255);
    sb.push_back('{sym: E_DAH, cyc: cyc + DEB + 2});
    after_mark = 1'b1;
    space(25);
    check_eq("sat_count", strobes - base, 3);

    // Reset in the middle of a mark discards it
    base = strobes;
    check_eq("sb_drained", sb.size(), 0);
    hold(1'b1, 6);
    rst = 1'b1;
    key_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("midreset_valid", int'(sym_valid), 0);
    check_eq("midreset_sym", int'(ditDah), 1);
    hold(1'b0, 12);
    check_eq("midreset_count", strobes - base, 0);
    mark(4); space(25);
    check_eq("post_reset_count", strobes - base, 3);

    hold(1'b0, 10);
    check_eq("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/morse_key_rx.md
# morse_key_rx

Front-end symbol slicer between the channel and `morse_rx`. It takes the raw on/off keyed line from the channel, removes short glitches and measures mark and space durations in clock ticks. It emits one 2-bit dit, dah or gap symbol per detected element, with a one-cycle `sym_valid` strobe. `morse_rx` advances only on cycles where `sym_valid` is high.

## Interface
- `DIT_TICKS`, 4: nominal length of one Morse unit in `clk` cycles; must be ≥ 2.
- `DEBOUNCE`, 2: consecutive cycles a level change must persist before it is accepted; ≥ 1.
- `CNT_W`, 8: duration counter width; 2^CNT_W − 1 ≥ 5·DIT_TICKS.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `key_in`  in  1  keyed line from the channel; 1 = mark (tone on), 0 = space.
- `ditDah`  out  [0:1]  symbol code: 2'b00 dit, 2'b11 dah, 2'b01 gap.
- `sym_valid`  out  1  one-cycle strobe; `ditDah` is meaningful only while it is high.

## Operation
- **Debounce.**
  - `key_in` is registered into `key_q`.
  - `key_db` (reset 0) toggles when `key_q != key_db` has held for `DEBOUNCE` consecutive cycles.
  - Any shorter excursion resets the persistence count and is ignored.
- **Counter.** `dur` counts cycles since the last `key_db` edge. It saturates at 2^CNT_W − 1 and never wraps. It clears on every accepted edge.
- **States:**
  - IDLE: space, no letter pending.
    - `key_db` rise → MARK.
  - MARK: counting the mark.
    - `key_db` fall → emit dit if `dur < 2·DIT_TICKS`, else emit dah → SPACE.
  - SPACE: letter pending, counting the space.
    - `key_db` rise → MARK with no emission (intra-letter gap).
    - `dur` reaching `2·DIT_TICKS` → emit gap (letter end) → WSPACE.
  - WSPACE: letter closed, waiting for a word gap.
    - `key_db` rise → MARK.
    - `dur` reaching `5·DIT_TICKS` → emit a second gap (word separator) → IDLE.
- **Symbol meaning downstream.** `morse_rx` decodes the second gap from its start node as letter code 0, which is the word separator.
- **Emission.** `ditDah` and `sym_valid` are registered. `ditDah` holds its last value between strobes.
- **Overlong mark.** A saturated mark is still classified as dah.
- **Reset.**
  - All state returns to IDLE, `key_db` = 0, `dur` = 0.
  - Reset mid-mark discards the partial element; nothing is emitted.

## Timing
- **Reset values:** `ditDah` = 2'b01, `sym_valid` = 0, state IDLE.
- **Edge acceptance:** a raw `key_in` edge is accepted as a `key_db` edge `DEBOUNCE + 1` cycles later (1 register plus `DEBOUNCE` persistence cycles).
- **Dit/dah output:** `sym_valid` rises the cycle after the `key_db` fall, i.e. `DEBOUNCE + 2` cycles after the raw falling edge.
- **Gap output:** `sym_valid` rises the cycle after `dur` reaches its threshold.
- **Strobe width:** `sym_valid` is exactly 1 cycle. Two strobes are never adjacent, because minimum element spacing is ≥ `DEBOUNCE` + 1 cycles.
- **Simultaneous threshold and rise:** if `dur` hits a gap threshold on the same cycle `key_db` rises, the rise wins. No gap is emitted and the state goes to MARK.
- **Classification thresholds (`key_db` cycles):**
  - mark < 2·DIT_TICKS → dit, else dah;
  - space ≥ 2·DIT_TICKS → letter gap;
  - space ≥ 5·DIT_TICKS → word gap.

## Structure
- **Package `morse_pkg`:**
  - symbol constants `SYM_DIT` = 2'b00, `SYM_DAH` = 2'b11, `SYM_GAP` = 2'b01;
  - state encoding IDLE/MARK/SPACE/WSPACE.
  - `morse_rx` and `morse_tx` migrate to the same symbol constants.
- **Sub-module `key_debounce`:** input register plus persistence counter. Ports `clk`, `rst`, `key_in`, `key_db`; parameter `DEBOUNCE`.
- **Top level:** `morse_key_rx` holds the FSM, `dur` and the output registers.

## Test plan
All scenarios use DIT_TICKS = 4, DEBOUNCE = 2, CNT_W = 8.
- **Letter A then word gap:** mark 4, space 4, mark 12, space 30 → strobes 00, 11, 01, 01 in that order. Exactly four `sym_valid` pulses, each 1 cycle.
- **Dit/dah boundary:** mark of 7 `key_db` cycles → 00; mark of 8 → 11.
- **Glitch rejection:** 1-cycle high pulse in a long space, and 1-cycle low dropout inside a 12-cycle mark → no extra strobes; the mark still yields a single 11.
- **Gap boundaries:** after a dit, space of 7 cycles then mark → no gap strobe; space of 8 → one 01; space of 19 → no second 01; space of 20 → second 01.
- **Saturation:** 300-cycle mark → single 11; `dur` holds 255, no wrap.
- **Reset mid-mark:** assert `rst` for 1 cycle during a mark → no strobe; `ditDah` = 01, `sym_valid` = 0 the next cycle. A following clean dit then decodes as 00.
